// File: rtl/hex_serial_tx.sv
// 6-bit parallel-to-serial framer: start, D1..D6 (LSB first), optional parity, stop.
// SO drops one cycle after an accepted LOAD; LOAD is ignored unless RDY (IDLE only).
module hex_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic CLK,
  input  logic CLR,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic D4,
  input  logic D5,
  input  logic D6,
  input  logic LOAD,
  output logic RDY,
  output logic SO,
  output logic BUSY,
  output logic DONE
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);

  state_t     state, state_n;
  logic [7:0] timer, timer_n;
  logic [2:0] idx, idx_n;
  logic [5:0] shadow, shadow_n;
  logic       tick_end;
  logic       so_n, rdy_n, busy_n, done_n;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state  <= IDLE;
      timer  <= '0;
      idx    <= '0;
      shadow <= '0;
      SO     <= 1'b1;
      RDY    <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      idx    <= idx_n;
      shadow <= shadow_n;
      SO     <= so_n;
      RDY    <= rdy_n;
      BUSY   <= busy_n;
      DONE   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer + 8'd1;
    idx_n    = idx;
    shadow_n = shadow;
    tick_end = (timer == LAST_TICK);

    case (state)
      IDLE: begin
        timer_n = '0;
        if (LOAD) begin
          state_n  = START;
          shadow_n = {D6, D5, D4, D3, D2, D1};
        end
      end
      START: begin
        if (tick_end) begin
          state_n = DATA;
          timer_n = '0;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (tick_end) begin
          timer_n = '0;
          if (idx == 3'd5) begin
            idx_n   = '0;
            state_n = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick_end) begin
          state_n = STOP;
          timer_n = '0;
        end
      end
      STOP: begin
        if (tick_end) begin
          state_n = IDLE;
          timer_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
        idx_n   = '0;
      end
    endcase

    // Outputs are precomputed from the next state so the registers carry them directly.
    so_n = 1'b1;
    case (state_n)
      START:   so_n = 1'b0;
      DATA:    so_n = shadow_n[idx_n];
      PARITY:  so_n = (^shadow_n) ^ PARITY_ODD;
      default: so_n = 1'b1;
    endcase
    rdy_n  = (state_n == IDLE);
    busy_n = ~rdy_n;
    done_n = (state_n == STOP) && (timer_n == LAST_TICK);
  end

endmodule

// File: tb/tb_hex_serial_tx.sv
// Directed bench over four parameterisations; per-cycle expected SO/BUSY/RDY/DONE come from a scoreboard queue.
module tb_hex_serial_tx;

  typedef struct packed {
    logic so;
    logic busy;
    logic done;
  } exp_t;

  logic       CLK;
  logic       CLR;
  logic [5:0] d;
  logic [3:0] load;
  logic [3:0] so_w, rdy_w, busy_w, done_w;

  int cpb_of  [4] = '{4, 4, 4, 1};
  int pen_of  [4] = '{1, 1, 0, 1};
  int podd_of [4] = '{0, 1, 1, 0};

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  hex_serial_tx u0 (
    .CLK(CLK), .CLR(CLR), .D1(d[0]), .D2(d[1]), .D3(d[2]), .D4(d[3]), .D5(d[4]), .D6(d[5]),
    .LOAD(load[0]), .RDY(rdy_w[0]), .SO(so_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]));

  hex_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u1 (
    .CLK(CLK), .CLR(CLR), .D1(d[0]), .D2(d[1]), .D3(d[2]), .D4(d[3]), .D5(d[4]), .D6(d[5]),
    .LOAD(load[1]), .RDY(rdy_w[1]), .SO(so_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]));

  hex_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b1)) u2 (
    .CLK(CLK), .CLR(CLR), .D1(d[0]), .D2(d[1]), .D3(d[2]), .D4(d[3]), .D5(d[4]), .D6(d[5]),
    .LOAD(load[2]), .RDY(rdy_w[2]), .SO(so_w[2]), .BUSY(busy_w[2]), .DONE(done_w[2]));

  hex_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u3 (
    .CLK(CLK), .CLR(CLR), .D1(d[0]), .D2(d[1]), .D3(d[2]), .D4(d[3]), .D5(d[4]), .D6(d[5]),
    .LOAD(load[3]), .RDY(rdy_w[3]), .SO(so_w[3]), .BUSY(busy_w[3]), .DONE(done_w[3]));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected line behaviour for one frame plus the idle cycle that follows it.
  task automatic push_frame(input int i, input logic [5:0] w);
    int   cpb, len, slot;
    exp_t e;
    cpb = cpb_of[i];
    len = (8 + pen_of[i]) * cpb;
    for (int c = 0; c < len; c++) begin
      slot   = c / cpb;
      e.busy = 1'b1;
      e.done = (c == len - 1);
      if (slot == 0)                         e.so = 1'b0;
      else if (slot <= 6)                    e.so = w[slot-1];
      else if (slot == 7 && pen_of[i] == 1)  e.so = (^w) ^ podd_of[i][0];
      else                                   e.so = 1'b1;
      sb.push_back(e);
    end
    e.so = 1'b1; e.busy = 1'b0; e.done = 1'b0;
    sb.push_back(e);
  endtask

  task automatic run(input int i, input logic [5:0] w, input logic [5:0] w2, input int nfr,
                     input bit chg, input bit rej, input int abort_at);
    int   total, flen;
    exp_t e;
    flen = (8 + pen_of[i]) * cpb_of[i];
    push_frame(i, w);
    if (nfr == 2) push_frame(i, w2);
    total   = sb.size();
    d       = w;
    load[i] = 1'b1;
    for (int c = 1; c <= total; c++) begin
      @(negedge CLK);
      if (c == abort_at) begin
        #2 CLR = 1'b0;
        #1;
        chk($sformatf("u%0d abort so", i), int'(so_w[i]), 1);
        chk($sformatf("u%0d abort busy", i), int'(busy_w[i]), 0);
        chk($sformatf("u%0d abort rdy", i), int'(rdy_w[i]), 1);
        chk($sformatf("u%0d abort done", i), int'(done_w[i]), 0);
        sb.delete();
        load[i] = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        return;
      end
      e = sb.pop_front();
      chk($sformatf("u%0d c%0d so", i, c), int'(so_w[i]), int'(e.so));
      chk($sformatf("u%0d c%0d busy", i, c), int'(busy_w[i]), int'(e.busy));
      chk($sformatf("u%0d c%0d rdy", i, c), int'(rdy_w[i]), int'(!e.busy));
      chk($sformatf("u%0d c%0d done", i, c), int'(done_w[i]), int'(e.done));
      if (c == 1) begin
        if (nfr == 1) load[i] = 1'b0;
        if (chg) d = ~w;
        if (nfr == 2) d = w2;
      end
      if (rej && c == 10) begin
        load[i] = 1'b1;
        d       = 6'h3f;
      end
      if (rej && c == 20) load[i] = 1'b0;
      if (nfr == 2 && c == flen + 2) load[i] = 1'b0;
    end
    chk($sformatf("u%0d scoreboard drained", i), sb.size(), 0);
  endtask

  initial begin
    CLR  = 1'b0;
    load = '0;
    d    = '0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d reset so", i), int'(so_w[i]), 1);
      chk($sformatf("u%0d reset rdy", i), int'(rdy_w[i]), 1);
      chk($sformatf("u%0d reset busy", i), int'(busy_w[i]), 0);
      chk($sformatf("u%0d reset done", i), int'(done_w[i]), 0);
    end

    // Release reset and request in the same cycle: accepted on the first rising edge.
    CLR = 1'b1;
    run(0, 6'b101101, 6'b0, 1, 1'b0, 1'b0, 0);
    run(0, 6'b000000, 6'b0, 1, 1'b0, 1'b1, 0);
    run(0, 6'b110010, 6'b0, 1, 1'b1, 1'b0, 0);
    run(1, 6'b000111, 6'b0, 1, 1'b0, 1'b0, 0);
    run(2, 6'b000111, 6'b0, 1, 1'b0, 1'b0, 0);
    run(3, 6'b101101, 6'b0, 1, 1'b0, 1'b0, 0);
    run(3, 6'b100110, 6'b011001, 2, 1'b0, 1'b0, 0);
    run(0, 6'b111001, 6'b0, 1, 1'b0, 1'b0, 14);
    run(0, 6'b011011, 6'b0, 1, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
